// File: rtl/ifu_prefetch_pkg.sv
// ifu_prefetch_pkg: shared constants and the fetch-entry bundle
// exchanged between the prefetch queue and decode.
package ifu_prefetch_pkg;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// ifu_fetch_fifo: registered in-order queue with flush; the head reads
// as zero while empty so downstream sees clean idle values.
module ifu_fetch_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push  = push && (count != CW'(DEPTH));
  assign do_pop   = pop && (count != '0);
  assign pop_data = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: AXI4-Lite instruction prefetcher with credit-based
// in-order queue, redirect flush and stale-beat dropping.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int                ADDR_W          = 32,
  parameter int                DATA_W          = 32,
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 4,
  parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              io_master_arvalid,
  input  logic              io_master_arready,
  output logic [ADDR_W-1:0] io_master_araddr,
  input  logic              io_master_rvalid,
  output logic              io_master_rready,
  input  logic [1:0]        io_master_rresp,
  input  logic [DATA_W-1:0] io_master_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault
);

  localparam int CW  = $clog2(MAX_OUTSTANDING + 2);
  localparam int EW  = ADDR_W + DATA_W + 1;
  localparam int DCW = $clog2(DEPTH + 1);
  localparam int PCW = $clog2(MAX_OUTSTANDING + 1);

  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic              pend_q;
  logic              stale_q;
  logic              halted_q;
  logic [CW-1:0]     in_flight_q;
  logic [CW-1:0]     drop_q;

  logic              can_issue;
  logic              ar_hs;
  logic              r_beat;
  logic              r_keep;
  logic              r_err;
  logic [DATA_W-1:0] r_inst;
  logic [DCW-1:0]    dcount;
  logic [PCW-1:0]    pcount;
  logic [ADDR_W-1:0] pc_head;
  logic [EW-1:0]     push_entry;
  logic [EW-1:0]     head_entry;

  assign can_issue = !rst && !halted_q
                  && (in_flight_q < CW'(MAX_OUTSTANDING))
                  && ((int'(in_flight_q) + int'(dcount)) < DEPTH);

  assign io_master_arvalid = pend_q || can_issue;
  assign io_master_araddr  = pend_q ? pend_addr_q : fetch_pc_q;
  assign io_master_rready  = 1'b1;

  assign ar_hs  = io_master_arvalid && io_master_arready;
  assign r_beat = io_master_rvalid && (in_flight_q != '0);
  assign r_err  = (io_master_rresp != RESP_OKAY);
  assign r_keep = r_beat && !redirect_valid
               && (drop_q == '0) && (pcount != '0);
  assign r_inst = r_err ? '0 : io_master_rdata;

  assign push_entry = {pc_head, r_inst, r_err};

  // PCs of live requests, oldest first; stale ARs never enter it
  ifu_fetch_fifo #(
    .W     (ADDR_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (ar_hs && !stale_q),
    .push_data (io_master_araddr),
    .pop       (r_keep),
    .pop_data  (pc_head),
    .count     (pcount)
  );

  ifu_fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (r_keep),
    .push_data (push_entry),
    .pop       (inst_ready),
    .pop_data  (head_entry),
    .count     (dcount)
  );

  assign inst_valid = (dcount != '0);
  assign {inst_pc, inst, inst_fault} = head_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      pend_addr_q <= RESET_PC;
      pend_q      <= 1'b0;
      stale_q     <= 1'b0;
      halted_q    <= 1'b0;
      in_flight_q <= '0;
      drop_q      <= '0;
    end else begin
      pend_q      <= io_master_arvalid && !io_master_arready;
      pend_addr_q <= io_master_araddr;
      stale_q     <= io_master_arvalid && !io_master_arready
                  && (redirect_valid || stale_q);
      in_flight_q <= in_flight_q + CW'(ar_hs) - CW'(r_beat);
      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc;
        halted_q   <= 1'b0;
        // every beat still owed, including a held or accepted AR
        drop_q     <= in_flight_q - CW'(r_beat)
                    + CW'(io_master_arvalid);
      end else begin
        if (ar_hs && !stale_q)
          fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
        if (r_beat && (drop_q != '0))
          drop_q <= drop_q - CW'(1);
        if (r_keep && r_err)
          halted_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed scenarios against a 2-cycle AXI-Lite
// memory stub with hand-computed expected fetch streams.
module tb_ifu_prefetch;
  import ifu_prefetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  always #5 clk = ~clk;

  ifu_prefetch dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .io_master_arvalid (arvalid),
    .io_master_arready (arready),
    .io_master_araddr  (araddr),
    .io_master_rvalid  (rvalid),
    .io_master_rready  (rready),
    .io_master_rresp   (rresp),
    .io_master_rdata   (rdata),
    .inst_valid        (inst_valid),
    .inst_ready        (inst_ready),
    .inst              (inst),
    .inst_pc           (inst_pc),
    .inst_fault        (inst_fault)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc, ar_limit, rsp_limit, rsp_cnt, cur_if, max_if;
  int first_beat, first_inst;
  logic [31:0] err_addr;
  logic [31:0] ar_log[$];
  logic [31:0] req_q[$];
  int          due_q[$];
  fetch_entry_t pops[$];

  task automatic set_ar_limit(input int n);
    ar_limit = n;
    arready  = (ar_log.size() < ar_limit);
  endtask

  // observe at negedge, advance one clock, then drive the memory stub
  task automatic tick();
    @(negedge clk);
    if (rvalid) begin
      void'(req_q.pop_front());
      void'(due_q.pop_front());
      rsp_cnt++;
      cur_if--;
      if (first_beat < 0) first_beat = cyc;
    end
    if (arvalid && arready) begin
      ar_log.push_back(araddr);
      req_q.push_back(araddr);
      due_q.push_back(cyc + 2);
      cur_if++;
      if (cur_if > max_if) max_if = cur_if;
    end
    if (inst_valid && first_inst < 0) first_inst = cyc;
    if (inst_valid && inst_ready)
      pops.push_back('{pc: inst_pc, inst: inst, fault: inst_fault});
    @(posedge clk);
    #1;
    cyc++;
    arready = (ar_log.size() < ar_limit);
    if (due_q.size() > 0 && due_q[0] <= cyc && rsp_cnt < rsp_limit) begin
      rvalid = 1'b1;
      rresp  = (req_q[0] == err_addr) ? 2'b10 : 2'b00;
      rdata  = 32'h0000_0013;
    end else begin
      rvalid = 1'b0;
      rresp  = 2'b00;
      rdata  = 32'h0;
    end
  endtask

  task automatic reset_assert();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    rvalid = 1'b0;
    rresp = 2'b00;
    rdata = 32'h0;
    arready = 1'b0;
    inst_ready = 1'b0;
    ar_limit = 0;
    rsp_limit = 1000;
    err_addr = 32'hFFFF_FFFF;
    ar_log.delete();
    req_q.delete();
    due_q.delete();
    pops.delete();
    rsp_cnt = 0;
    cur_if = 0;
    max_if = 0;
    first_beat = -1;
    first_inst = -1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_release();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic do_reset();
    reset_assert();
    reset_release();
  endtask

  task automatic test_reset();
    reset_assert();
    n_vec++;
    if (arvalid !== 1'b0) begin
      n_err++; $display("FAIL rst_arvalid: got %b want 0", arvalid);
    end
    n_vec++;
    if (araddr !== 32'h8000_0000) begin
      n_err++; $display("FAIL rst_araddr: got %h want 80000000", araddr);
    end
    n_vec++;
    if (rready !== 1'b1) begin
      n_err++; $display("FAIL rst_rready: got %b want 1", rready);
    end
    n_vec++;
    if (inst_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid);
    end
    n_vec++;
    if ({inst, inst_pc, inst_fault} !== 65'h0) begin
      n_err++;
      $display("FAIL rst_head: got %h/%h/%b want 0/0/0",
               inst, inst_pc, inst_fault);
    end
    reset_release();
    #1;
    n_vec++;
    if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL first_ar: got %b/%h want 1/80000000", arvalid, araddr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    set_ar_limit(1000);
    inst_ready = 1'b1;
    repeat (24) tick();
    n_vec++;
    if (ar_log.size() < 8 || pops.size() < 16) begin
      n_err++;
      $display("FAIL stream_rate: got %0d ars %0d pops want >=8 >=16",
               ar_log.size(), pops.size());
    end
    for (int i = 0; i < 8 && i < ar_log.size(); i++) begin
      n_vec++;
      if (ar_log[i] !== 32'h8000_0000 + 32'(4 * i)) begin
        n_err++;
        $display("FAIL stream_araddr[%0d]: got %h want %h",
                 i, ar_log[i], 32'h8000_0000 + 32'(4 * i));
      end
    end
    for (int i = 0; i < 8 && i < pops.size(); i++) begin
      n_vec++;
      if (pops[i].pc !== 32'h8000_0000 + 32'(4 * i)
          || pops[i].inst !== 32'h13 || pops[i].fault !== 1'b0) begin
        n_err++;
        $display("FAIL stream_pop[%0d]: got %h/%h/%b want %h/00000013/0",
                 i, pops[i].pc, pops[i].inst, pops[i].fault,
                 32'h8000_0000 + 32'(4 * i));
      end
    end
    n_vec++;
    if (max_if > 4) begin
      n_err++; $display("FAIL stream_in_flight: got %0d want <=4", max_if);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_ar_limit(1000);
    inst_ready = 1'b0;
    repeat (12) tick();
    #1;
    n_vec++;
    if (ar_log.size() != 4 || arvalid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_credit: got %0d ars arvalid %b want 4 ars arvalid 0",
               ar_log.size(), arvalid);
    end
    n_vec++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0000) begin
      n_err++;
      $display("FAIL bp_head: got %b/%h want 1/80000000", inst_valid, inst_pc);
    end
    n_vec++;
    if (first_inst != first_beat + 1) begin
      n_err++;
      $display("FAIL bp_latency: got inst at %0d want %0d",
               first_inst, first_beat + 1);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    repeat (8) tick();
    #1;
    n_vec++;
    if (ar_log.size() != 5 || pops.size() != 1) begin
      n_err++;
      $display("FAIL bp_resume: got %0d ars %0d pops want 5 1",
               ar_log.size(), pops.size());
    end else if (ar_log[4] !== 32'h8000_0010) begin
      n_err++;
      $display("FAIL bp_resume_addr: got %h want 80000010", ar_log[4]);
    end
    n_vec++;
    if (inst_pc !== 32'h8000_0004) begin
      n_err++; $display("FAIL bp_next_head: got %h want 80000004", inst_pc);
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    set_ar_limit(1000);
    rsp_limit = 1;
    inst_ready = 1'b0;
    repeat (10) tick();
    #1;
    n_vec++;
    if (ar_log.size() != 4 || arvalid !== 1'b0 || inst_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rdi_setup: got %0d ars arvalid %b valid %b want 4 0 1",
               ar_log.size(), arvalid, inst_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    #1;
    n_vec++;
    if (inst_valid !== 1'b0 || arvalid !== 1'b1 || araddr !== 32'h8000_1000) begin
      n_err++;
      $display("FAIL rdi_restart: got %b/%b/%h want 0/1/80001000",
               inst_valid, arvalid, araddr);
    end
    rsp_limit = 1000;
    inst_ready = 1'b1;
    repeat (12) tick();
    n_vec++;
    if (ar_log.size() < 5 || pops.size() < 2) begin
      n_err++;
      $display("FAIL rdi_after: got %0d ars %0d pops want >=5 >=2",
               ar_log.size(), pops.size());
    end else if (ar_log[4] !== 32'h8000_1000 || pops[0].pc !== 32'h8000_1000
                 || pops[1].pc !== 32'h8000_1004 || pops[0].inst !== 32'h13) begin
      n_err++;
      $display("FAIL rdi_stream: got ar %h pops %h %h want 80001000 80001000 80001004",
               ar_log[4], pops[0].pc, pops[1].pc);
    end
  endtask

  task automatic test_redirect_pending();
    do_reset();
    set_ar_limit(2);
    rsp_limit = 0;
    inst_ready = 1'b0;
    repeat (5) tick();
    #1;
    n_vec++;
    if (arvalid !== 1'b1 || araddr !== 32'h8000_0008) begin
      n_err++;
      $display("FAIL rdp_held: got %b/%h want 1/80000008", arvalid, araddr);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    #1;
    n_vec++;
    if (arvalid !== 1'b1 || araddr !== 32'h8000_0008) begin
      n_err++;
      $display("FAIL rdp_hold_redirect: got %b/%h want 1/80000008",
               arvalid, araddr);
    end
    set_ar_limit(1000);
    rsp_limit = 1000;
    inst_ready = 1'b1;
    repeat (14) tick();
    n_vec++;
    if (ar_log.size() < 4 || pops.size() < 1) begin
      n_err++;
      $display("FAIL rdp_after: got %0d ars %0d pops want >=4 >=1",
               ar_log.size(), pops.size());
    end else if (ar_log[2] !== 32'h8000_0008 || ar_log[3] !== 32'h8000_1000
                 || pops[0].pc !== 32'h8000_1000) begin
      n_err++;
      $display("FAIL rdp_order: got ar %h %h pop %h want 80000008 80001000 80001000",
               ar_log[2], ar_log[3], pops[0].pc);
    end
  endtask

  task automatic test_fault();
    do_reset();
    err_addr = 32'h8000_0004;
    set_ar_limit(1000);
    inst_ready = 1'b0;
    repeat (10) tick();
    #1;
    n_vec++;
    if (ar_log.size() != 4 || arvalid !== 1'b0 || inst_pc !== 32'h8000_0000
        || inst_fault !== 1'b0) begin
      n_err++;
      $display("FAIL flt_setup: got %0d ars %b %h %b want 4 0 80000000 0",
               ar_log.size(), arvalid, inst_pc, inst_fault);
    end
    inst_ready = 1'b1;
    tick();
    #1;
    n_vec++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0004
        || inst_fault !== 1'b1 || inst !== 32'h0) begin
      n_err++;
      $display("FAIL flt_entry: got %b/%h/%b/%h want 1/80000004/1/00000000",
               inst_valid, inst_pc, inst_fault, inst);
    end
    repeat (8) tick();
    #1;
    n_vec++;
    if (ar_log.size() != 4 || inst_valid !== 1'b0 || pops.size() != 4) begin
      n_err++;
      $display("FAIL flt_halted: got %0d ars valid %b %0d pops want 4 0 4",
               ar_log.size(), inst_valid, pops.size());
    end else if (pops[2].fault !== 1'b0 || pops[2].pc !== 32'h8000_0008) begin
      n_err++;
      $display("FAIL flt_tail: got %h/%b want 80000008/0",
               pops[2].pc, pops[2].fault);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_2000;
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();
    n_vec++;
    if (ar_log.size() < 5 || pops.size() < 5) begin
      n_err++;
      $display("FAIL flt_restart: got %0d ars %0d pops want >=5 >=5",
               ar_log.size(), pops.size());
    end else if (ar_log[4] !== 32'h8000_2000 || pops[4].pc !== 32'h8000_2000
                 || pops[4].fault !== 1'b0 || pops[4].inst !== 32'h13) begin
      n_err++;
      $display("FAIL flt_restart_data: got ar %h pop %h/%b/%h want 80002000 80002000/0/00000013",
               ar_log[4], pops[4].pc, pops[4].fault, pops[4].inst);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_pending();
    test_fault();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction-fetch unit with an in-order prefetch queue. It sits between the PC/redirect logic and the instruction-side AXI4-Lite read master port. It keeps up to MAX_OUTSTANDING read requests in flight and buffers returned instructions in a DEPTH-entry FIFO toward decode. It supports pipeline redirects, discarding stale responses, and reports bus errors as fetch faults.

## Interface
Parameters:
- ADDR_W, 32, address and PC width
- DATA_W, 32, instruction width
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered AR requests; 1..DEPTH
- RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  new fetch address, 4-byte aligned
- io_master_arvalid  out  1  read address valid
- io_master_arready  in  1  read address ready
- io_master_araddr  out  ADDR_W  read address
- io_master_rvalid  in  1  read data valid
- io_master_rready  out  1  read data ready
- io_master_rresp  in  2  read response; nonzero means error
- io_master_rdata  in  DATA_W  read data
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode accepts head
- inst  out  DATA_W  head instruction
- inst_pc  out  ADDR_W  head PC
- inst_fault  out  1  head is a bus-error entry; inst is 0

## Operation
- State: fetch_pc, in_flight count (0..MAX_OUTSTANDING), drop count (0..MAX_OUTSTANDING), halted flag, FIFO of {pc, inst, fault}.
- AR issue: arvalid is raised when all of the following hold: !halted; in_flight < MAX_OUTSTANDING; in_flight + fifo_count < DEPTH. araddr = fetch_pc.
- On the AR handshake: fetch_pc += 4 (wraps modulo 2^ADDR_W), in_flight += 1.
- AXI rule: once arvalid is high, arvalid and araddr are held until arready, including across a redirect.
- R channel: rready is held at 1 permanently. FIFO space is pre-reserved by the credit rule, so overflow is impossible.
- On an R beat, in_flight -= 1.
  - If drop > 0: drop -= 1 and the beat is discarded.
  - Otherwise a FIFO entry is pushed with the PC of the oldest outstanding request (a PC FIFO or counter is kept in parallel).
- Error response (rresp ≠ 0) on a non-dropped beat: push {pc, 0, fault=1} and set halted. No further AR is issued until a redirect.
- Redirect:
  - FIFO cleared.
  - drop = in_flight after this cycle's updates, plus 1 if an AR is pending or handshaking this cycle.
  - fetch_pc = redirect_pc; halted cleared.
  - A pending unaccepted AR keeps its old address, and its beat is dropped.
- Simultaneous events:
  - redirect + R beat in the same cycle: the beat is dropped.
  - redirect + inst_ready: the pop is irrelevant because the FIFO is cleared.
  - push + pop in the same cycle: count is unchanged.
- rst mid-transaction: all state returns to reset values immediately. The surrounding system guarantees the interconnect is reset together with this block.

## Timing
- Reset values: arvalid 0, araddr RESET_PC, rready 1, inst_valid 0, inst 0, inst_pc 0, inst_fault 0; counters 0, halted 0.
- First arvalid is asserted in the first cycle after rst deasserts.
- R beat accepted at cycle t → inst_valid at cycle t+1 (registered FIFO, no bypass).
- Redirect at t with no pending AR → arvalid with redirect_pc at t+1.
- Steady-state throughput is one instruction per cycle when arready and rvalid permit and DEPTH ≥ round-trip latency.

## Structure
- Shared package holds:
  - RESP_OKAY = 2'b00;
  - default RESET_PC;
  - fetch-entry struct {pc, inst, fault}.
- Sub-module ifu_fetch_fifo: synchronous FIFO with DEPTH entries, width ADDR_W+DATA_W+1, and a flush input. It also serves as the in-order PC tracking queue, as a second instance with depth MAX_OUTSTANDING.

## Test plan
- Reset release, arready=1, memory returns rdata=0x00000013 after 2 cycles → araddr sequence 0x80000000, 0x80000004, …; inst_pc follows the same sequence; in_flight never exceeds 4.
- inst_ready=0 with DEPTH=4 → exactly 4 ARs are accepted, then arvalid stays 0. Asserting inst_ready resumes fetch one entry per pop.
- Redirect to 0x80001000 with 3 requests in flight → the 3 returning beats are discarded, the FIFO is empty, and the next araddr is 0x80001000.
- Redirect while arvalid=1 and arready=0 at 0x80000008 → araddr stays 0x80000008 until accepted; its beat is dropped; the following AR is 0x80001000.
- rresp=2'b10 on the request for 0x80000004 → entry with inst_fault=1, inst=0, inst_pc=0x80000004; no further AR until a redirect, after which fetch restarts.
